// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if
// Bundles the EX-side and MEM-side handshake and data signals of the
// EX/MEM skid buffer, the flush request and the stall counter output.
//   slave  : the buffer view (ex_* / flush_i / mem_ready_i in,
//            ex_ready_o / mem_* / stall_cnt_o out)
//   master : the surrounding pipeline view (directions reversed)
// Optional macro EX_MEM_SKID_FWD_EN adds fwd_we_o / fwd_wd_o / fwd_wdata_o.
interface ex_mem_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              flush_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_wd_o;
  logic              mem_wreg_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`ifdef EX_MEM_SKID_FWD_EN
  logic              fwd_we_o;
  logic [ADDR_W-1:0] fwd_wd_o;
  logic [DATA_W-1:0] fwd_wdata_o;
`endif

  modport slave (
`ifdef EX_MEM_SKID_FWD_EN
    output fwd_we_o, output fwd_wd_o, output fwd_wdata_o,
`endif
    input  ex_valid_i, input ex_wd_i, input ex_wreg_i, input ex_wdata_i,
    input  flush_i, input mem_ready_i,
    output ex_ready_o, output mem_valid_o, output mem_wd_o,
    output mem_wreg_o, output mem_wdata_o, output stall_cnt_o
  );

  modport master (
`ifdef EX_MEM_SKID_FWD_EN
    input  fwd_we_o, input fwd_wd_o, input fwd_wdata_o,
`endif
    output ex_valid_i, output ex_wd_i, output ex_wreg_i, output ex_wdata_i,
    output flush_i, output mem_ready_i,
    input  ex_ready_o, input mem_valid_o, input mem_wd_o,
    input  mem_wreg_o, input mem_wdata_o, input stall_cnt_o
  );
endinterface

// File: rtl/ex_mem_skid.sv
// ex_mem_skid
// Two-entry elastic buffer replacing the EX/MEM register. A main entry
// drives MEM, a skid entry absorbs one extra result while MEM stalls, so
// ex_ready_o depends only on registered state (no ready path MEM -> EX).
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : ex_mem_skid_if.slave (EX handshake + data, flush, MEM
//           handshake + data, saturating MEM back-pressure counter)
// Optional macro EX_MEM_SKID_FWD_EN: forwarding of the youngest buffered
// entry towards ID (fwd_we_o / fwd_wd_o / fwd_wdata_o).
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  ex_mem_skid_if.slave    bus
);

  // Entry layout: {wd, wreg, wdata}
  localparam int ENT_W = ADDR_W + 1 + DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ENT_W-1:0] main_r;
  logic [ENT_W-1:0] skid_r;
  logic [ENT_W-1:0] in_s;
  logic [CNT_W-1:0] cnt_r;
  logic             push_s;
  logic             pop_s;
  logic             ex_ready_s;
  logic             mem_valid_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             skid_to_main_s;

  assign in_s   = {bus.ex_wd_i, bus.ex_wreg_i, bus.ex_wdata_i};
  assign push_s = bus.ex_valid_i & ex_ready_s;
  assign pop_s  = mem_valid_s & bus.mem_ready_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and entry-load decode; flush overrides everything and
  // suppresses all loads so a flushed push never reaches MEM
  always_comb begin
    state_nxt_s    = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    if (bus.flush_i) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && !pop_s) begin
            state_nxt_s = ST_TWO;
            load_skid_s = 1'b1;
          end else if (push_s && pop_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else if (pop_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_nxt_s    = ST_ONE;
            skid_to_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    ex_ready_s  = 1'b1;
    mem_valid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        ex_ready_s  = 1'b1;
        mem_valid_s = 1'b0;
      end
      ST_ONE: begin
        ex_ready_s  = 1'b1;
        mem_valid_s = 1'b1;
      end
      ST_TWO: begin
        ex_ready_s  = 1'b0;
        mem_valid_s = 1'b1;
      end
      default: begin
        ex_ready_s  = 1'b1;
        mem_valid_s = 1'b0;
      end
    endcase
  end

  // Main entry: loaded from EX or refilled from skid; holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_r <= '0;
    end else if (load_main_s) begin
      main_r <= in_s;
    end else if (skid_to_main_s) begin
      main_r <= skid_r;
    end
  end

  // Skid entry: written only when a push arrives while MEM is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_r <= '0;
    end else if (load_skid_s) begin
      skid_r <= in_s;
    end
  end

  // Saturating MEM back-pressure counter, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (mem_valid_s && !bus.mem_ready_i && !bus.flush_i && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.ex_ready_o  = ex_ready_s;
  assign bus.mem_valid_o = mem_valid_s;
  assign bus.mem_wd_o    = main_r[ENT_W-1 -: ADDR_W];
  assign bus.mem_wreg_o  = main_r[DATA_W] & mem_valid_s;
  assign bus.mem_wdata_o = main_r[DATA_W-1:0];
  assign bus.stall_cnt_o = cnt_r;

`ifdef EX_MEM_SKID_FWD_EN
  logic [ENT_W-1:0] fwd_ent_s;
  logic             fwd_hit_s;

  // Youngest valid entry: skid when two are held, else main
  always_comb begin
    fwd_ent_s = main_r;
    fwd_hit_s = 1'b0;
    case (state_r)
      ST_TWO: begin
        fwd_ent_s = skid_r;
        fwd_hit_s = 1'b1;
      end
      ST_ONE: begin
        fwd_ent_s = main_r;
        fwd_hit_s = 1'b1;
      end
      default: begin
        fwd_ent_s = main_r;
        fwd_hit_s = 1'b0;
      end
    endcase
  end

  assign bus.fwd_we_o    = fwd_hit_s & fwd_ent_s[DATA_W] & ~bus.flush_i;
  assign bus.fwd_wd_o    = fwd_ent_s[ENT_W-1 -: ADDR_W];
  assign bus.fwd_wdata_o = fwd_ent_s[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid
// Directed scenarios plus randomized traffic for ex_mem_skid, checked
// against a queue-based model of a two-deep FIFO with flush and a
// saturating stall counter. CNT_W is 4 so saturation is reachable.
module tb_ex_mem_skid;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  ent_t q[$];
  int   m_cnt = 0;
  ent_t m_last = '0;

  ex_mem_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();

  ex_mem_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input ent_t e, input logic rdy, input logic fl);
    bus.ex_valid_i  = v;
    bus.ex_wd_i     = e.wd;
    bus.ex_wreg_i   = e.wreg;
    bus.ex_wdata_i  = e.wdata;
    bus.mem_ready_i = rdy;
    bus.flush_i     = fl;
  endtask

  // Model: FIFO of at most two entries; flush empties it
  task automatic model_edge();
    bit   pop;
    bit   push;
    ent_t in_e;
    pop  = (q.size() > 0) && bus.mem_ready_i;
    push = bus.ex_valid_i && (q.size() < 2);
    in_e = {bus.ex_wd_i, bus.ex_wreg_i, bus.ex_wdata_i};
    if (bus.flush_i) begin
      q.delete();
    end else begin
      if ((q.size() > 0) && !bus.mem_ready_i && (m_cnt < CNT_MAX)) m_cnt++;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_e);
    end
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got=%0h exp=1", bus.ex_ready_o); end
    checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0h exp=0", bus.mem_valid_o); end
    checks++; if (bus.mem_wreg_o !== 1'b0) begin failures++; $display("FAIL reset_mem_wreg got=%0h exp=0", bus.mem_wreg_o); end
    checks++; if (bus.mem_wd_o !== 5'd0) begin failures++; $display("FAIL reset_mem_wd got=%0h exp=0", bus.mem_wd_o); end
    checks++; if (bus.mem_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata_o); end
    checks++; if (bus.stall_cnt_o !== 4'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0h exp=0", bus.stall_cnt_o); end
    apply_reset();
  endtask

  task automatic test_single();
    ent_t e;
    apply_reset();
    e = {5'd5, 1'b1, 32'h0000_00FF};
    drive(1'b1, e, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%0h exp=0", bus.mem_valid_o); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", bus.mem_valid_o); end
    checks++; if (bus.mem_wd_o !== 5'd5) begin failures++; $display("FAIL single_wd got=%0h exp=5", bus.mem_wd_o); end
    checks++; if (bus.mem_wdata_o !== 32'hFF) begin failures++; $display("FAIL single_wdata got=%0h exp=ff", bus.mem_wdata_o); end
    checks++; if (bus.mem_wreg_o !== 1'b1) begin failures++; $display("FAIL single_wreg got=%0h exp=1", bus.mem_wreg_o); end
    step();
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%0h exp=0", bus.mem_valid_o); end
    checks++; if (bus.mem_wreg_o !== 1'b0) begin failures++; $display("FAIL single_drain_wreg got=%0h exp=0", bus.mem_wreg_o); end
    checks++; if (bus.mem_wdata_o !== 32'hFF) begin failures++; $display("FAIL single_hold_wdata got=%0h exp=ff", bus.mem_wdata_o); end
  endtask

  task automatic test_stream();
    ent_t e;
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      e = {ADDR_W'(i), 1'b1, DATA_W'(i)};
      drive(1'b1, e, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (bus.ex_ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready[%0d] got=%0h exp=1", i, bus.ex_ready_o); end
      if (i > 1) begin
        checks++; if (bus.mem_valid_o !== 1'b1 || bus.mem_wdata_o !== DATA_W'(i - 1)) begin failures++; $display("FAIL stream_out[%0d] got valid=%0h data=%0h exp valid=1 data=%0h", i, bus.mem_valid_o, bus.mem_wdata_o, i - 1); end
      end
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b1 || bus.mem_wdata_o !== 32'd8) begin failures++; $display("FAIL stream_last got valid=%0h data=%0h exp valid=1 data=8", bus.mem_valid_o, bus.mem_wdata_o); end
    step();
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%0h exp=0", bus.mem_valid_o); end
  endtask

  task automatic test_backpressure();
    ent_t a;
    ent_t b;
    ent_t c;
    apply_reset();
    a = {5'd1, 1'b1, 32'hA};
    b = {5'd2, 1'b0, 32'hB};
    c = {5'd3, 1'b1, 32'hC};
    drive(1'b1, a, 1'b0, 1'b0);
    step();
    drive(1'b1, b, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.ex_ready_o !== 1'b1 || bus.mem_wdata_o !== 32'hA) begin failures++; $display("FAIL bp_one got ready=%0h data=%0h exp ready=1 data=a", bus.ex_ready_o, bus.mem_wdata_o); end
    step();
    drive(1'b1, c, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.ex_ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0h exp=0", bus.ex_ready_o); end
`ifdef EX_MEM_SKID_FWD_EN
    checks++; if (bus.fwd_wd_o !== 5'd2 || bus.fwd_we_o !== 1'b0) begin failures++; $display("FAIL bp_fwd got wd=%0h we=%0h exp wd=2 we=0", bus.fwd_wd_o, bus.fwd_we_o); end
`endif
    step();
    drive(1'b1, c, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.ex_ready_o !== 1'b0 || bus.mem_wdata_o !== 32'hA) begin failures++; $display("FAIL bp_hold got ready=%0h data=%0h exp ready=0 data=a", bus.ex_ready_o, bus.mem_wdata_o); end
    checks++; if (bus.stall_cnt_o !== 4'd2) begin failures++; $display("FAIL bp_cnt got=%0d exp=2", bus.stall_cnt_o); end
    step();
    @(negedge clk);
    checks++; if (bus.mem_wdata_o !== 32'hB || bus.mem_wreg_o !== 1'b0 || bus.mem_valid_o !== 1'b1) begin failures++; $display("FAIL bp_out_b got data=%0h wreg=%0h valid=%0h exp data=b wreg=0 valid=1", bus.mem_wdata_o, bus.mem_wreg_o, bus.mem_valid_o); end
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_wdata_o !== 32'hC || bus.mem_wreg_o !== 1'b1 || bus.mem_wd_o !== 5'd3) begin failures++; $display("FAIL bp_out_c got data=%0h wreg=%0h wd=%0h exp data=c wreg=1 wd=3", bus.mem_wdata_o, bus.mem_wreg_o, bus.mem_wd_o); end
    step();
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0 || bus.stall_cnt_o !== 4'd2) begin failures++; $display("FAIL bp_end got valid=%0h cnt=%0d exp valid=0 cnt=2", bus.mem_valid_o, bus.stall_cnt_o); end
  endtask

  task automatic test_flush();
    ent_t x;
    ent_t y;
    ent_t z;
    ent_t w;
    ent_t v;
    apply_reset();
    x = {5'd7, 1'b1, 32'h1111};
    y = {5'd8, 1'b1, 32'h2222};
    z = {5'd9, 1'b1, 32'h3333};
    w = {5'd10, 1'b1, 32'h4444};
    v = {5'd11, 1'b1, 32'h5555};
    drive(1'b1, x, 1'b0, 1'b0);
    step();
    drive(1'b1, y, 1'b0, 1'b0);
    step();
    drive(1'b1, z, 1'b0, 1'b1);
    @(negedge clk);
`ifdef EX_MEM_SKID_FWD_EN
    checks++; if (bus.fwd_we_o !== 1'b0) begin failures++; $display("FAIL flush_fwd_we got=%0h exp=0", bus.fwd_we_o); end
`endif
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0 || bus.ex_ready_o !== 1'b1) begin failures++; $display("FAIL flush_two got valid=%0h ready=%0h exp valid=0 ready=1", bus.mem_valid_o, bus.ex_ready_o); end
    checks++; if (bus.stall_cnt_o !== 4'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", bus.stall_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL flush_quiet[%0d] got=%0h exp=0", i, bus.mem_valid_o); end
    end
    drive(1'b1, w, 1'b0, 1'b0);
    step();
    drive(1'b1, v, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b0 || bus.mem_wdata_o !== 32'h4444) begin failures++; $display("FAIL flush_one got valid=%0h data=%0h exp valid=0 data=4444", bus.mem_valid_o, bus.mem_wdata_o); end
    checks++; if (bus.stall_cnt_o !== 4'd1) begin failures++; $display("FAIL flush_one_cnt got=%0d exp=1", bus.stall_cnt_o); end
  endtask

  task automatic test_async_reset();
    ent_t p;
    ent_t r;
    apply_reset();
    p = {5'd21, 1'b1, 32'hDEAD_BEEF};
    r = {5'd12, 1'b1, 32'h0BAD_CAFE};
    drive(1'b1, p, 1'b0, 1'b0);
    step();
    drive(1'b1, r, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_last = '0;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b1 || bus.mem_valid_o !== 1'b0 || bus.mem_wreg_o !== 1'b0) begin failures++; $display("FAIL arst_hs got ready=%0h valid=%0h wreg=%0h exp 1 0 0", bus.ex_ready_o, bus.mem_valid_o, bus.mem_wreg_o); end
    checks++; if (bus.mem_wd_o !== 5'd0 || bus.mem_wdata_o !== 32'd0 || bus.stall_cnt_o !== 4'd0) begin failures++; $display("FAIL arst_data got wd=%0h data=%0h cnt=%0d exp 0 0 0", bus.mem_wd_o, bus.mem_wdata_o, bus.stall_cnt_o); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, r, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.mem_valid_o !== 1'b1 || bus.mem_wdata_o !== 32'h0BAD_CAFE || bus.mem_wd_o !== 5'd12) begin failures++; $display("FAIL arst_after got valid=%0h data=%0h wd=%0h exp 1 badcafe c", bus.mem_valid_o, bus.mem_wdata_o, bus.mem_wd_o); end
    step();
  endtask

  task automatic test_saturation();
    ent_t s;
    int   exp;
    apply_reset();
    s = {5'd3, 1'b1, 32'h77};
    drive(1'b1, s, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      @(negedge clk);
      exp = (k < CNT_MAX) ? k : CNT_MAX;
      checks++; if (bus.stall_cnt_o !== CNT_W'(exp)) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, bus.stall_cnt_o, exp); end
    end
    checks++; if (bus.mem_valid_o !== 1'b1 || bus.mem_wdata_o !== 32'h77) begin failures++; $display("FAIL sat_hold got valid=%0h data=%0h exp 1 77", bus.mem_valid_o, bus.mem_wdata_o); end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    ent_t e;
    ent_t hd;
    logic v;
    logic rdy;
    logic fl;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      e.wd    = ADDR_W'($urandom);
      e.wreg  = 1'($urandom);
      e.wdata = $urandom;
      v   = ($urandom_range(3, 0) != 0);
      rdy = ($urandom_range(4, 0) < 3);
      fl  = ($urandom_range(15, 0) == 0);
      drive(v, e, rdy, fl);
      @(negedge clk);
      hd = (q.size() > 0) ? q[0] : m_last;
      checks++; if (bus.ex_ready_o !== (q.size() < 2) || bus.mem_valid_o !== (q.size() > 0)) begin failures++; $display("FAIL rnd_hs[%0d] got ready=%0h valid=%0h exp depth=%0d", n, bus.ex_ready_o, bus.mem_valid_o, q.size()); end
      checks++; if (bus.mem_wd_o !== hd.wd || bus.mem_wdata_o !== hd.wdata || bus.mem_wreg_o !== (hd.wreg & (q.size() > 0))) begin failures++; $display("FAIL rnd_data[%0d] got wd=%0h data=%0h wreg=%0h exp wd=%0h data=%0h", n, bus.mem_wd_o, bus.mem_wdata_o, bus.mem_wreg_o, hd.wd, hd.wdata); end
      checks++; if (bus.stall_cnt_o !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, bus.stall_cnt_o, m_cnt); end
`ifdef EX_MEM_SKID_FWD_EN
      if (q.size() > 0) begin
        checks++; if (bus.fwd_wd_o !== q[$].wd || bus.fwd_wdata_o !== q[$].wdata || bus.fwd_we_o !== (q[$].wreg & ~fl)) begin failures++; $display("FAIL rnd_fwd[%0d] got wd=%0h we=%0h exp wd=%0h", n, bus.fwd_wd_o, bus.fwd_we_o, q[$].wd); end
      end else begin
        checks++; if (bus.fwd_we_o !== 1'b0) begin failures++; $display("FAIL rnd_fwd_empty[%0d] got=%0h exp=0", n, bus.fwd_we_o); end
      end
`endif
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Elastic pipeline buffer between the EX stage result outputs (destination address, write-enable, write data) and the MEM stage input.
- Two-entry skid buffer with a valid/ready handshake on both sides. It replaces the bare EX/MEM register, so MEM-side back-pressure (multi-cycle memory access) never creates a combinational ready path back into EX.
- Also supports a synchronous pipeline flush and provides a saturating back-pressure cycle counter.

Parameters:
- DATA_W, 32, width of the result data word (matches RegBus).
- ADDR_W, 5, width of the destination register address (matches RegAddrBus).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- ex_valid_i  in  1  EX presents a result this cycle.
- ex_ready_o  out  1  buffer can accept an EX result this cycle.
- ex_wd_i  in  ADDR_W  destination register address from EX.
- ex_wreg_i  in  1  register write-enable from EX.
- ex_wdata_i  in  DATA_W  result data from EX.
- flush_i  in  1  synchronous flush; drops all buffered and incoming results.
- mem_valid_o  out  1  MEM-side result valid.
- mem_ready_i  in  1  MEM accepts the result this cycle.
- mem_wd_o  out  ADDR_W  destination address to MEM.
- mem_wreg_o  out  1  write-enable to MEM; gated by mem_valid_o.
- mem_wdata_o  out  DATA_W  result data to MEM.
- stall_cnt_o  out  CNT_W  saturating count of MEM back-pressure cycles.

Behaviour:
- Storage: a main entry that drives the mem_* outputs, and a skid entry. Each entry holds {wd, wreg, wdata}.
- State machine: EMPTY (no valid entries), ONE (main valid), TWO (main and skid valid). Encoded in registers.
- Handshakes: push = ex_valid_i & ex_ready_o; pop = mem_valid_o & mem_ready_i.
- Transitions when flush_i = 0:
  - EMPTY: push -> ONE, input loaded into main.
  - ONE: push & !pop -> TWO, input loaded into skid. push & pop -> ONE, input loaded into main. !push & pop -> EMPTY. Otherwise hold.
  - TWO: pop -> ONE, skid moved to main. push is impossible because ready is 0.
- ex_ready_o = (state != TWO); it is a function of registered state only.
- mem_valid_o = (state != EMPTY); it comes from a register, with no combinational path from any ex_* input.
- Ordering: strict FIFO. Latency from push to mem_valid_o is 1 cycle. Throughput is one result per cycle when mem_ready_i is held at 1.
- Entries with ex_wreg_i = 0 are buffered and delivered like any other (bubble and non-writing instructions keep their slot).
- mem_wreg_o = main.wreg & mem_valid_o.
- mem_wd_o and mem_wdata_o hold their last value when EMPTY. Consumers must qualify them with mem_valid_o.
- Flush:
  - flush_i = 1 forces the next state to EMPTY.
  - A push in the same cycle is discarded; a pop in the same cycle still counts as completed for MEM.
  - Flush has priority over every other event.
- Stall counter:
  - Increments by 1 in each cycle where mem_valid_o = 1, mem_ready_i = 0 and flush_i = 0.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Reset (asynchronous, any time, including with TWO entries occupied):
  - State becomes EMPTY; both entries are cleared to zero.
  - Output values: ex_ready_o = 1, mem_valid_o = 0, mem_wreg_o = 0, mem_wd_o = 0, mem_wdata_o = 0, stall_cnt_o = 0.
  - Buffered results are lost.
- No X propagation: all entry registers are reset. The skid entry is written only on push in state ONE with !pop.

Optional Feature:
- Macro EX_MEM_SKID_FWD_EN adds forwarding outputs toward ID:
  - fwd_we_o (1 bit), fwd_wd_o (ADDR_W bits), fwd_wdata_o (DATA_W bits).
  - They describe the youngest valid buffered entry: skid if state is TWO, else main if state is ONE.
  - fwd_we_o = that entry's wreg. fwd_we_o = 0 when EMPTY or when flush_i = 1.
  - The outputs are combinational from registered state.
- Without the macro, these ports and their logic do not exist and the module interface is exactly the list above.

Test Plan:
- Reset, then push {wd=5, wreg=1, wdata=0x0000_00FF} with mem_ready_i=1 -> next cycle mem_valid_o=1, mem_wd_o=5, mem_wdata_o=0xFF, mem_wreg_o=1; the following cycle mem_valid_o=0.
- Streaming: push 8 results wdata=1..8 back-to-back with mem_ready_i=1 -> ex_ready_o stays 1; outputs 1..8 appear in order on consecutive cycles.
- Back-pressure: mem_ready_i=0 and push A, B, C -> A and B accepted, ex_ready_o=0 after B, C held by EX. Then mem_ready_i=1 -> outputs A, B, C in order; stall_cnt_o equals the number of stalled valid cycles.
- Flush in state TWO with a simultaneous push -> next cycle mem_valid_o=0, ex_ready_o=1; no buffered or incoming data ever appears at MEM.
- Assert rst=0 asynchronously mid-cycle while in state TWO -> outputs immediately take the reset values listed above; after release, a new push emerges normally.
- Counter saturation with CNT_W=4: hold mem_valid_o=1 and mem_ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays there. With EX_MEM_SKID_FWD_EN, in state TWO fwd_wd_o equals the skid entry's wd.
